mdu_16: RTL

Iterative 16×16 multiply unit for the mycpu datapath. It sits directly downstream of the 3-input operand multiplexer: the selected operand drives `a_in`, and the product registers feed back into the writeback path. Multiplication is shift-add, one multiplier bit per cycle, with a start/busy/done handshake. Both unsigned and signed (two's complement) modes are supported.

---
 rtl/mycpu_pkg.sv | 28 ++
 rtl/mdu_16.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mycpu_pkg.sv
// ---------------------------------------------------------------------------
// mycpu_pkg -- shared types and constants for the mycpu datapath.
//   word_t       : 16-bit datapath word
//   mdu_state_t  : control states of the iterative multiplier (mdu_16)
//   MDU_CYCLES   : number of shift-add iterations per multiply
//   CLK_PERIOD   : nominal clock period used by simulation clock generators
//   mag16()      : magnitude of a word, optionally treating it as signed
// ---------------------------------------------------------------------------
package mycpu_pkg;

   localparam int WORD_W     = 16;
   localparam int MDU_CYCLES = 16;
   localparam int CLK_PERIOD = 10;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      MDU_IDLE,
      MDU_RUN,
      MDU_DONE
   } mdu_state_t;

   // -32768 maps to 0x8000, which is still exact as an unsigned 16-bit value.
   function automatic word_t mag16(input word_t v, input logic is_signed);
      return (is_signed && v[WORD_W-1]) ? word_t'(-v) : v;
   endfunction

endpackage

// File: rtl/mdu_16.sv
// ---------------------------------------------------------------------------
// mdu_16 -- iterative 16x16 shift-add multiplier, one multiplier bit per cycle.
// Signed mode multiplies magnitudes and negates the 32-bit result at the end.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset
//   start_in   : request a multiply (accepted in IDLE or DONE)
//   signed_in  : 1 = two's complement operands, captured with start_in
//   a_in       : multiplicand
//   b_in       : multiplier
//   busy_out   : high while the shift-add loop is running
//   done_out   : one-cycle pulse when the product registers are updated
//   p_lo_out   : product bits [15:0]
//   p_hi_out   : product bits [31:16]
//   zero_out   : full 32-bit product is zero (held until next result)
// ---------------------------------------------------------------------------
module mdu_16
   import mycpu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_in,
   input  logic             signed_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] p_lo_out,
   output logic [WIDTH-1:0] p_hi_out,
   output logic             zero_out
);

   localparam int               CNT_W    = $clog2(MDU_CYCLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MDU_CYCLES - 1);

   mdu_state_t         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   mcand_q;
   // Upper half is the accumulator, lower half holds the remaining multiplier bits.
   logic [2*WIDTH-1:0] prod_q;
   logic               neg_q;

   logic [WIDTH:0]     sum_d;
   logic [2*WIDTH-1:0] prod_d;
   logic [2*WIDTH-1:0] result_d;
   logic               accept;
   logic               last_step;

   assign accept    = start_in && (state_q != MDU_RUN);
   assign last_step = (state_q == MDU_RUN) && (cnt_q == LAST_CNT);

   // One shift-add step; the 17-bit sum carries into the top bit of the shift.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sum_d    = '0;
      prod_d   = '0;
      result_d = '0;
      sum_d    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
               + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      prod_d   = {sum_d, prod_q[WIDTH-1:1]};
      result_d = neg_q ? -prod_d : prod_d;
   end

   // Control FSM with registered busy/done.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all flops so every block sees pre-edge values.
      if (rst) begin
         state_q  <= MDU_IDLE;
         cnt_q    <= '0;
         busy_out <= 1'b0;
         done_out <= 1'b0;
      end else begin
         case (state_q)
            MDU_IDLE, MDU_DONE: begin
               done_out <= 1'b0;
               if (start_in) begin
                  state_q  <= MDU_RUN;
                  cnt_q    <= '0;
                  busy_out <= 1'b1;
               end else begin
                  state_q  <= MDU_IDLE;
                  busy_out <= 1'b0;
               end
            end
            MDU_RUN: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_q  <= MDU_DONE;
                  busy_out <= 1'b0;
                  done_out <= 1'b1;
               end
            end
            default: begin
               state_q  <= MDU_IDLE;
               busy_out <= 1'b0;
               done_out <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: operand capture, iteration, and result registers.
   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too, so a reset mid-run leaves no stale product visible.
      if (rst) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         neg_q    <= 1'b0;
         p_lo_out <= '0;
         p_hi_out <= '0;
         zero_out <= 1'b1;
      end else if (accept) begin
         mcand_q <= mag16(a_in, signed_in);
         prod_q  <= {{WIDTH{1'b0}}, mag16(b_in, signed_in)};
         neg_q   <= signed_in && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
      end else if (state_q == MDU_RUN) begin
         prod_q <= prod_d;
         if (last_step) begin
            p_lo_out <= result_d[WIDTH-1:0];
            p_hi_out <= result_d[2*WIDTH-1:WIDTH];
            zero_out <= (result_d == '0);
         end
      end
   end

endmodule
